// File: rtl/mux_nw_rr_pkg.sv
// Shared encodings for the N-channel round-robin registered mux.
// Mode select values and lock FSM state codes.
package mux_nw_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

endpackage

// File: rtl/mux_nw_rr_if.sv
// Streaming bundle between N input channels and the single output of mux_nw_rr.
// master drives channels and out_ready; slave is the mux.
interface mux_nw_rr_if #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
);
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic [SELW-1:0]   out_chan;
    logic              out_ready;

    modport master (
        output mode, sel, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_chan
    );

    modport slave (
        input  mode, sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_chan
    );
endinterface

// File: rtl/mux_nw_rr_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] grant_o,
    output logic            any_o
);

    always_comb begin : pick_c
        int unsigned idx;
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!any_o && (idx == i) && req_i[i]) begin
                    grant_o = SELW'(i);
                    any_o   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_nw_rr.sv
// N-channel W-bit registered mux with fixed/round-robin grant and a one-entry output register.
// Optional packet lock compiled in with MUX_NW_RR_LOCK_EN.
module mux_nw_rr
    import mux_nw_rr_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic        clk,
    input  logic        rst,
    mux_nw_rr_if.slave  bus
);

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [SELW-1:0]   out_chan_q,  out_chan_d;
    logic [SELW-1:0]   ptr_q,       ptr_d;

    logic [SELW-1:0]   rr_idx;
    logic              rr_any;
    logic [SELW-1:0]   grant;
    logic              grant_ok;
    logic              can_accept;
    logic              xfer;
    logic              adv;
    logic              sel_valid;
    logic              sel_last;
    logic [W-1:0]      sel_data;
    logic [W-1:0]      ch_data [N];

`ifdef MUX_NW_RR_LOCK_EN
    lock_st_e          lock_st_q, lock_st_d;
    logic [SELW-1:0]   lock_ch_q, lock_ch_d;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        assign ch_data[gi] = bus.in_data[gi*W +: W];
    end

    rr_pick #(.N(N), .SELW(SELW)) u_pick (
        .req_i   (bus.in_valid),
        .ptr_i   (ptr_q),
        .grant_o (rr_idx),
        .any_o   (rr_any)
    );

    // Grant: lock overrides mode; fixed select out of range grants nothing.
    always_comb begin : grant_c
        grant    = bus.sel;
        grant_ok = (32'(bus.sel) < N);
        if (bus.mode == MODE_RR) begin
            grant    = rr_idx;
            grant_ok = rr_any;
        end
`ifdef MUX_NW_RR_LOCK_EN
        if (lock_st_q == ST_LOCKED) begin
            grant    = lock_ch_q;
            grant_ok = 1'b1;
        end
`endif
    end

    always_comb begin : route_c
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                sel_valid = bus.in_valid[i];
                sel_data  = ch_data[i];
                sel_last  = bus.in_last[i];
            end
        end
    end

    assign can_accept = !out_valid_q || bus.out_ready;
    assign xfer       = grant_ok && sel_valid && can_accept && !rst;

    always_comb begin : ready_c
        bus.in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_ok && can_accept && !rst && (grant == SELW'(i))) begin
                bus.in_ready[i] = 1'b1;
            end
        end
    end

`ifdef MUX_NW_RR_LOCK_EN
    assign adv = xfer && sel_last;
`else
    assign adv = xfer;
`endif

    always_comb begin : next_c
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_chan_d  = grant;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (adv && (bus.mode == MODE_RR)) begin
            ptr_d = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
        end
`ifdef MUX_NW_RR_LOCK_EN
        lock_st_d = lock_st_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            lock_st_d = sel_last ? ST_OPEN : ST_LOCKED;
            lock_ch_d = grant;
        end
`endif
    end

    always_ff @(posedge clk) begin : state_q
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
`ifdef MUX_NW_RR_LOCK_EN
            lock_st_q   <= ST_OPEN;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
`ifdef MUX_NW_RR_LOCK_EN
            lock_st_q   <= lock_st_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nw_rr.sv
// Self-checking bench for mux_nw_rr (N=4, W=8, SELW=3); lock cases follow MUX_NW_RR_LOCK_EN.
module tb_mux_nw_rr;

    localparam int unsigned W    = 8;
    localparam int unsigned N    = 4;
    localparam int unsigned SELW = 3;

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [3:0] inv;
        logic [3:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [2:0] chan;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_nw_rr_if #(.W(W), .N(N), .SELW(SELW)) bus ();

    mux_nw_rr #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic       mode;
    logic [2:0] sel;
    logic [3:0] inv;
    logic [3:0] lst;
    logic       ordy;
    logic [7:0] chd [4];

    logic       m_ov;
    logic       m_lock;
    logic [2:0] m_ptr;
    logic [2:0] m_lch;
    beat_t      sb [$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.mode      = mode;
        bus.sel       = sel;
        bus.in_valid  = inv;
        bus.in_last   = lst;
        bus.out_ready = ordy;
        for (int i = 0; i < 4; i++) bus.in_data[i*8 +: 8] = chd[i];
    endtask

    task automatic mgrant(output logic ok, output logic [2:0] g);
        ok = 1'b0;
        g  = 3'd0;
        if (m_lock) begin
            ok = 1'b1;
            g  = m_lch;
        end else if (!mode) begin
            ok = (sel < 3'd4);
            g  = sel;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (int'(m_ptr) + k) % 4;
                if (!ok && inv[c]) begin
                    ok = 1'b1;
                    g  = 3'(c);
                end
            end
        end
    endtask

    // One clock: check current outputs against the model, then advance it.
    task automatic cycle();
        logic       ok, can, xfer, adv;
        logic [2:0] g;
        logic [3:0] er;
        beat_t      b;
        drive();
        #1;
        mgrant(ok, g);
        can = !m_ov || ordy;
        er  = (ok && can && !rst) ? 4'(4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov && sb.size() > 0) begin
            b = sb[0];
            chk("out_data", 32'(bus.out_data), 32'(b.data));
            chk("out_last", 32'(bus.out_last), 32'(b.last));
            chk("out_chan", 32'(bus.out_chan), 32'(b.chan));
        end
        @(posedge clk);
        if (rst) begin
            m_ov   = 1'b0;
            m_ptr  = 3'd0;
            m_lock = 1'b0;
            sb.delete();
        end else begin
            xfer = ok && can && inv[g[1:0]];
            if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());
            if (xfer) begin
                b.data = chd[g[1:0]];
                b.last = lst[g[1:0]];
                b.chan = g;
                sb.push_back(b);
                chd[g[1:0]] = chd[g[1:0]] + 8'd1;
            end
            m_ov = xfer || (m_ov && !ordy);
`ifdef MUX_NW_RR_LOCK_EN
            if (xfer) begin
                m_lock = !lst[g[1:0]];
                m_lch  = g;
            end
            adv = xfer && lst[g[1:0]];
`else
            adv = xfer;
`endif
            if (adv && mode) m_ptr = (g == 3'd3) ? 3'd0 : g + 3'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [8];
        int         rr_a [8];
        int         rr_b [4];
        int         lk   [4];
        int         n1;
        logic [7:0] held;

        tbl[0] = '{mode: 1'b0, sel: 3'd2, inv: 4'b0100, exp_rdy: 4'b0100};
        tbl[1] = '{mode: 1'b0, sel: 3'd5, inv: 4'b1111, exp_rdy: 4'b0000};
        tbl[2] = '{mode: 1'b0, sel: 3'd0, inv: 4'b0000, exp_rdy: 4'b0001};
        tbl[3] = '{mode: 1'b0, sel: 3'd3, inv: 4'b1000, exp_rdy: 4'b1000};
        tbl[4] = '{mode: 1'b0, sel: 3'd7, inv: 4'b1111, exp_rdy: 4'b0000};
        tbl[5] = '{mode: 1'b1, sel: 3'd0, inv: 4'b0000, exp_rdy: 4'b0000};
        tbl[6] = '{mode: 1'b1, sel: 3'd1, inv: 4'b0100, exp_rdy: 4'b0100};
        tbl[7] = '{mode: 1'b0, sel: 3'd1, inv: 4'b0010, exp_rdy: 4'b0010};
        rr_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        rr_b = '{1, 3, 1, 3};
`ifdef MUX_NW_RR_LOCK_EN
        lk = '{1, 1, 1, 2};
`else
        lk = '{1, 2, 3, 0};
`endif

        mode = 1'b0; sel = 3'd0; inv = 4'hF; lst = 4'hF; ordy = 1'b1;
        for (int i = 0; i < 4; i++) chd[i] = 8'(16 * i + 1);
        m_ov = 1'b0; m_ptr = 3'd0; m_lock = 1'b0; m_lch = 3'd0;

        // First edge brings the DUT out of X; model checks start afterwards.
        rst = 1'b1;
        drive();
        @(posedge clk);
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_chan", 32'(bus.out_chan), 32'h0);
        chk("rst_out_last", 32'(bus.out_last), 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            mode = tbl[v].mode; sel = tbl[v].sel; inv = tbl[v].inv;
            drive();
            #1;
            chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[v].exp_rdy));
            cycle();
        end

        mode = 1'b0; sel = 3'd2; inv = 4'b0100; chd[2] = 8'hA5;
        cycle();
        chk("fix_data", 32'(bus.out_data), 32'hA5);
        chk("fix_chan", 32'(bus.out_chan), 32'd2);

        do_reset();
        mode = 1'b1; inv = 4'b1111; ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_all_chan", 32'(bus.out_chan), 32'(rr_a[k]));
        end
        inv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_1010_chan", 32'(bus.out_chan), 32'(rr_b[k]));
        end

        mode = 1'b0; sel = 3'd1; inv = 4'b0010; ordy = 1'b1;
        cycle();
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chd[1] = 8'($urandom);
            cycle();
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        ordy = 1'b1;
        held = chd[1];
        cycle();
        chk("bp_nobubble_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_nobubble_data", 32'(bus.out_data), 32'(held));

        do_reset();
        mode = 1'b1; inv = 4'b0001; lst = 4'hF;
        cycle();
        inv = 4'b1111;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            lst = (n1 == 2) ? 4'b1111 : 4'b1101;
            cycle();
            chk("lock_seq_chan", 32'(bus.out_chan), 32'(lk[k]));
            if (lk[k] == 1) n1++;
        end

        lst = 4'hF;
        do_reset();
        inv = 4'b0001;
        cycle();
        inv = 4'b1111; lst = 4'b1101;
        cycle();
        chk("rst_lock_first", 32'(bus.out_chan), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        lst = 4'hF;
        cycle();
        chk("rst_lock_next", 32'(bus.out_chan), 32'd0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
